// File: rtl/decoder_pkg.sv
// rtl/decoder_pkg.sv - shared decode mode type and the per-channel address-to-code function
package decoder_pkg;

  typedef enum {DEC_ONEHOT = 0, DEC_THERMO = 1} dec_mode_e;

  localparam int MAX_BITS     = 8;
  localparam int MAX_OUT_BITS = 1 << MAX_BITS;

  // Callers narrow the result to their own OUT_BITS; bits above 1<<BITS are always zero.
  function automatic logic [MAX_OUT_BITS-1:0] dec_code(
    input logic [MAX_BITS-1:0] addr,
    input logic                en,
    input dec_mode_e           mode
  );
    logic [MAX_OUT_BITS-1:0] code;
    code = '0;
    for (int i = 0; i < MAX_OUT_BITS; i++) begin
      if (mode == DEC_ONEHOT) begin
        code[i] = en && (i == int'(addr));
      end else begin
        code[i] = en && (i <= int'(addr));
      end
    end
    return code;
  endfunction

endpackage

// File: rtl/dec_skid_buffer.sv
// rtl/dec_skid_buffer.sv - two-entry valid/ready skid buffer with a registered s_tready
module dec_skid_buffer #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] s_tdata,
  input  logic             s_tvalid,
  output logic             s_tready,
  output logic [WIDTH-1:0] m_tdata,
  output logic             m_tvalid,
  input  logic             m_tready
);

  logic [WIDTH-1:0] out_q;
  logic [WIDTH-1:0] skid_q;
  logic             out_vld_q;
  logic             skid_vld_q;
  logic             ready_q;
  logic             skid_vld_d;
  logic             accept;
  logic             load_out;

  assign accept   = s_tvalid & ready_q;
  assign load_out = !out_vld_q | m_tready;

  // The skid only fills when the output stage is stuck; any drain empties it.
  always_comb begin
    skid_vld_d = skid_vld_q;
    if (load_out) begin
      skid_vld_d = 1'b0;
    end else if (accept) begin
      skid_vld_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_q      <= '0;
      skid_q     <= '0;
      out_vld_q  <= 1'b0;
      skid_vld_q <= 1'b0;
      ready_q    <= 1'b1;
    end else begin
      skid_vld_q <= skid_vld_d;
      ready_q    <= !skid_vld_d;
      if (load_out) begin
        // A full skid implies ready_q=0, so the older skid beat never races a new accept.
        if (skid_vld_q) begin
          out_q     <= skid_q;
          out_vld_q <= 1'b1;
        end else if (accept) begin
          out_q     <= s_tdata;
          out_vld_q <= 1'b1;
        end else begin
          out_vld_q <= 1'b0;
        end
      end else if (accept) begin
        skid_q <= s_tdata;
      end
    end
  end

  assign s_tready = ready_q;
  assign m_tdata  = out_q;
  assign m_tvalid = out_vld_q;

endmodule

// File: rtl/pipelined_onehot_decoder.sv
// rtl/pipelined_onehot_decoder.sv - multi-channel registered one-hot/thermometer decoder
// Decoded codes plus their OR-reduction are stored in a skid buffer, not the raw addresses.
module pipelined_onehot_decoder
  import decoder_pkg::*;
#(
  parameter  int BITS     = 3,
  parameter  int CHANNELS = 1,
  parameter  int MODE     = 0,
  localparam int OUT_BITS = 1 << BITS
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [CHANNELS*BITS-1:0]     in_addr,
  input  logic [CHANNELS-1:0]          in_en,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [CHANNELS*OUT_BITS-1:0] out_y,
  output logic                         out_any
);

  localparam int WIDTH = CHANNELS * OUT_BITS + 1;

  if (BITS < 1) begin : g_bad_bits_lo
    $error("Bad BITS value %d", BITS);
  end
  if (BITS > 8) begin : g_bad_bits_hi
    $error("Bad BITS value %d", BITS);
  end
  if (CHANNELS < 1) begin : g_bad_channels
    $error("Bad CHANNELS value %d", CHANNELS);
  end
  if (MODE != 0 && MODE != 1) begin : g_bad_mode
    $error("Bad MODE value %d", MODE);
  end

  logic [CHANNELS*OUT_BITS-1:0] dec_y;
  logic [WIDTH-1:0]             m_tdata;

  for (genvar c = 0; c < CHANNELS; c++) begin : g_chan
    assign dec_y[c*OUT_BITS +: OUT_BITS] =
      OUT_BITS'(dec_code(MAX_BITS'(in_addr[c*BITS +: BITS]), in_en[c], dec_mode_e'(MODE)));
  end

  // out_any travels with its beat so a held output never needs recomputation.
  dec_skid_buffer #(
    .WIDTH(WIDTH)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tdata  ({|dec_y, dec_y}),
    .s_tvalid (in_valid),
    .s_tready (in_ready),
    .m_tdata  (m_tdata),
    .m_tvalid (out_valid),
    .m_tready (out_ready)
  );

  assign out_y   = m_tdata[WIDTH-2:0];
  assign out_any = m_tdata[WIDTH-1];

endmodule

// File: tb/tb_pipelined_onehot_decoder.sv
// tb/tb_pipelined_onehot_decoder.sv - randomized bench with a queue-based reference model
module tb_pipelined_onehot_decoder;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [5:0]  in_addr = '0;
  logic [1:0]  in_en = '0;
  logic        out_ready = 1'b0;

  logic        rdy0, rdy1, rdy2;
  logic        ov0, ov1, ov2;
  logic [15:0] y0, y1;
  logic [7:0]  y2;
  logic        any0, any1, any2;

  int checks = 0;
  int failures = 0;

  logic [15:0] q0[$];
  logic [15:0] q1[$];
  logic [15:0] q2[$];
  logic        exp_rdy;
  logic        exp_ov;

  always #5 clk = ~clk;

  pipelined_onehot_decoder #(.BITS(3), .CHANNELS(2), .MODE(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy0),
    .in_addr(in_addr), .in_en(in_en), .out_valid(ov0), .out_ready(out_ready),
    .out_y(y0), .out_any(any0)
  );

  pipelined_onehot_decoder #(.BITS(3), .CHANNELS(2), .MODE(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy1),
    .in_addr(in_addr), .in_en(in_en), .out_valid(ov1), .out_ready(out_ready),
    .out_y(y1), .out_any(any1)
  );

  pipelined_onehot_decoder #(.BITS(2), .CHANNELS(2), .MODE(0)) dut2 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(rdy2),
    .in_addr(in_addr[3:0]), .in_en(in_en), .out_valid(ov2), .out_ready(out_ready),
    .out_y(y2), .out_any(any2)
  );

  // One-hot is 1<<a, thermometer is 2^(a+1)-1, each channel shifted into its own field.
  function automatic logic [15:0] model_y(input int bits, input int mode,
                                          input logic [5:0] addr, input logic [1:0] en);
    int ob;
    int a;
    int v;
    logic [15:0] y;
    ob = 1 << bits;
    y  = '0;
    for (int c = 0; c < 2; c++) begin
      a = (int'(addr) >> (c * bits)) % ob;
      if (en[c]) begin
        v = (mode == 1) ? ((2 << a) - 1) : (1 << a);
        y = y | 16'(v << (c * ob));
      end
    end
    return y;
  endfunction

  task automatic drive(input logic v, input logic [5:0] a, input logic [1:0] e, input logic r);
    @(negedge clk);
    in_valid  = v;
    in_addr   = a;
    in_en     = e;
    out_ready = r;
    #1;
    exp_rdy = (q0.size() < 2);
    exp_ov  = (q0.size() > 0);
  endtask

  task automatic advance();
    logic acc;
    logic drn;
    acc = in_valid && (q0.size() < 2);
    drn = (q0.size() > 0) && out_ready;
    @(posedge clk);
    if (drn) begin
      void'(q0.pop_front());
      void'(q1.pop_front());
      void'(q2.pop_front());
    end
    if (acc) begin
      q0.push_back(model_y(3, 0, in_addr, in_en));
      q1.push_back(model_y(3, 1, in_addr, in_en));
      q2.push_back(model_y(2, 0, in_addr, in_en));
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++;
    if ({ov0, ov1, ov2, rdy0, rdy1, rdy2} !== 6'b000111) begin
      failures++;
      $display("FAIL reset_handshake: got %b want 000111", {ov0, ov1, ov2, rdy0, rdy1, rdy2});
    end
    checks++;
    if ({y0, y1, y2, any0, any1, any2} !== 43'd0) begin
      failures++;
      $display("FAIL reset_data: got %h want 0", {y0, y1, y2, any0, any1, any2});
    end
    rst_n = 1'b1;
  endtask

  task automatic test_stream();
    int accepts;
    accepts = 0;
    for (int i = 0; i < 9; i++) begin
      if (i < 8) drive(1'b1, 6'(i), 2'b01, 1'b1);
      else drive(1'b0, 6'd0, 2'b00, 1'b1);
      checks++;
      if ({rdy0, ov0} !== {exp_rdy, exp_ov} || exp_rdy !== 1'b1) begin
        failures++;
        $display("FAIL stream_handshake[%0d]: got rdy=%b ov=%b want rdy=1 ov=%b", i, rdy0, ov0, exp_ov);
      end
      if (i > 0) begin
        checks++;
        if (ov0 !== 1'b1 || y0 !== 16'(1 << (i - 1)) || any0 !== 1'b1) begin
          failures++;
          $display("FAIL stream_onehot[%0d]: got ov=%b y=%h any=%b want ov=1 y=%h any=1",
                   i, ov0, y0, any0, 16'(1 << (i - 1)));
        end
      end
      if (in_valid && rdy0) accepts++;
      advance();
    end
    checks++;
    if (accepts !== 8) begin
      failures++;
      $display("FAIL stream_throughput: got %0d accepts want 8", accepts);
    end
  endtask

  task automatic test_thermo();
    logic [5:0] addrs [4] = '{6'd0, 6'd5, 6'd7, 6'd7};
    logic [1:0] ens   [4] = '{2'b01, 2'b01, 2'b01, 2'b00};
    logic [7:0] wants [4] = '{8'h01, 8'h3F, 8'hFF, 8'h00};
    for (int k = 0; k < 4; k++) begin
      drive(1'b1, addrs[k], ens[k], 1'b1);
      advance();
      drive(1'b0, 6'd0, 2'b00, 1'b1);
      checks++;
      if (ov1 !== 1'b1 || y1 !== {8'h00, wants[k]} || any1 !== (wants[k] != 8'h00)) begin
        failures++;
        $display("FAIL thermo[%0d]: got ov=%b y=%h any=%b want ov=1 y=%h any=%b",
                 k, ov1, y1, any1, wants[k], wants[k] != 8'h00);
      end
      advance();
    end
  endtask

  task automatic test_multichannel();
    drive(1'b1, 6'b00_1101, 2'b01, 1'b1);
    advance();
    drive(1'b0, 6'd0, 2'b00, 1'b1);
    checks++;
    if (ov2 !== 1'b1 || y2 !== 8'h02 || any2 !== 1'b1) begin
      failures++;
      $display("FAIL multichannel: got ov=%b y=%h any=%b want ov=1 y=02 any=1", ov2, y2, any2);
    end
    advance();
  endtask

  task automatic test_backpressure();
    drive(1'b1, 6'd2, 2'b01, 1'b0);
    advance();
    drive(1'b1, 6'd6, 2'b01, 1'b0);
    advance();
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 6'd1, 2'b01, 1'b0);
      checks++;
      if (rdy0 !== 1'b0 || ov0 !== 1'b1 || y0 !== 16'h0004 || any0 !== 1'b1) begin
        failures++;
        $display("FAIL backpressure_hold[%0d]: got rdy=%b ov=%b y=%h want rdy=0 ov=1 y=0004",
                 i, rdy0, ov0, y0);
      end
      advance();
    end
    drive(1'b0, 6'd0, 2'b00, 1'b1);
    advance();
    drive(1'b0, 6'd0, 2'b00, 1'b1);
    checks++;
    if (rdy0 !== 1'b1 || ov0 !== 1'b1 || y0 !== 16'h0040) begin
      failures++;
      $display("FAIL backpressure_second: got rdy=%b ov=%b y=%h want rdy=1 ov=1 y=0040", rdy0, ov0, y0);
    end
    advance();
    drive(1'b0, 6'd0, 2'b00, 1'b1);
    checks++;
    if (ov0 !== 1'b0 || rdy0 !== 1'b1) begin
      failures++;
      $display("FAIL backpressure_drained: got ov=%b rdy=%b want ov=0 rdy=1", ov0, rdy0);
    end
    advance();
  endtask

  task automatic test_random();
    logic [15:0] e0, e1, e2;
    for (int i = 0; i < 400; i++) begin
      drive(1'($urandom_range(0, 1)), 6'($urandom), 2'($urandom), ($urandom_range(0, 3) != 0));
      checks++;
      if ({rdy0, rdy1, rdy2, ov0, ov1, ov2} !== {{3{exp_rdy}}, {3{exp_ov}}}) begin
        failures++;
        $display("FAIL random_handshake[%0d]: got %b want %b", i,
                 {rdy0, rdy1, rdy2, ov0, ov1, ov2}, {{3{exp_rdy}}, {3{exp_ov}}});
      end
      if (exp_ov) begin
        e0 = q0[0];
        e1 = q1[0];
        e2 = q2[0];
        checks++;
        if ({y0, y1, y2, any0, any1, any2} !== {e0, e1, e2[7:0], |e0, |e1, |e2}) begin
          failures++;
          $display("FAIL random_data[%0d]: got %h/%h/%h any=%b%b%b want %h/%h/%h", i,
                   y0, y1, y2, any0, any1, any2, e0, e1, e2[7:0]);
        end
      end
      advance();
    end
  endtask

  task automatic test_reset_mid();
    drive(1'b1, 6'd3, 2'b11, 1'b0);
    advance();
    drive(1'b1, 6'd4, 2'b11, 1'b0);
    advance();
    drive(1'b0, 6'd0, 2'b00, 1'b0);
    checks++;
    if ({rdy0, ov0} !== 2'b01) begin
      failures++;
      $display("FAIL reset_mid_full: got rdy=%b ov=%b want rdy=0 ov=1", rdy0, ov0);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({ov0, ov1, ov2, rdy0, rdy1, rdy2, any0} !== 7'b0001110) begin
      failures++;
      $display("FAIL reset_mid_async: got %b want 0001110", {ov0, ov1, ov2, rdy0, rdy1, rdy2, any0});
    end
    q0.delete();
    q1.delete();
    q2.delete();
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      drive(1'b0, 6'd0, 2'b00, 1'b1);
      checks++;
      if ({ov0, ov1, ov2} !== 3'b000 || rdy0 !== 1'b1) begin
        failures++;
        $display("FAIL reset_mid_stale[%0d]: got ov=%b rdy=%b want ov=000 rdy=1", i, {ov0, ov1, ov2}, rdy0);
      end
      advance();
    end
  endtask

  initial begin
    test_reset();
    test_stream();
    test_thermo();
    test_multichannel();
    test_backpressure();
    test_random();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
